// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: holds the pipeline while a load/store runs on the data bus.
// Optional MEM_TIMEOUT_EN macro adds a 256-cycle access timeout with a sticky mem_err flag.
module mem_access_ctrl (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] ans_me,
    input  logic [31:0] b_me,
    input  logic [4:0]  rw_me,
    input  logic        wreg_me,
    input  logic        m2reg_me,
    input  logic        wmem_me,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] ans_wb,
    output logic [31:0] mdata_wb,
    output logic [4:0]  rw_wb,
    output logic        wreg_wb,
    output logic        m2reg_wb,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ans_wb_q, ans_wb_d;
    logic [31:0] mdata_wb_q, mdata_wb_d;
    logic [4:0]  rw_wb_q, rw_wb_d;
    logic        wreg_wb_q, wreg_wb_d;
    logic        m2reg_wb_q, m2reg_wb_d;
    logic        err_q, err_d;
    logic        stall_c;
    logic        mem_op;
    logic        timeout;

    assign mem_op = m2reg_me | wmem_me;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counter is cleared outside ACCESS, so it reads k-1 on the k-th access cycle.
    always_comb begin
        cnt_d = 8'd0;
        if (state_q == ACCESS)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign timeout = (state_q == ACCESS) && !mem_ack && (cnt_q == 8'hFF);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ans_wb_d   = ans_wb_q;
        mdata_wb_d = mdata_wb_q;
        rw_wb_d    = rw_wb_q;
        wreg_wb_d  = wreg_wb_q;
        m2reg_wb_d = m2reg_wb_q;
        err_d      = err_q;
        stall_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_c   = 1'b1;
                    state_d   = ACCESS;
                    req_d     = 1'b1;
                    we_d      = wmem_me;
                    addr_d    = ans_me;
                    wdata_d   = b_me;
                    wreg_wb_d  = 1'b0;
                    m2reg_wb_d = 1'b0;
                end else begin
                    ans_wb_d   = ans_me;
                    mdata_wb_d = 32'd0;
                    rw_wb_d    = rw_me;
                    wreg_wb_d  = wreg_me;
                    m2reg_wb_d = 1'b0;
                end
            end
            ACCESS: begin
                stall_c    = 1'b1;
                wreg_wb_d  = 1'b0;
                m2reg_wb_d = 1'b0;
                // A same-cycle ack beats the timeout and leaves mem_err alone.
                if (mem_ack || timeout) begin
                    rdata_d = (mem_ack && !we_q) ? mem_rdata : 32'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                    err_d   = err_q | timeout;
                end
            end
            DONE: begin
                ans_wb_d   = ans_me;
                mdata_wb_d = rdata_q;
                rw_wb_d    = rw_me;
                wreg_wb_d  = wreg_me;
                m2reg_wb_d = m2reg_me & ~wmem_me;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            ans_wb_q   <= 32'd0;
            mdata_wb_q <= 32'd0;
            rw_wb_q    <= 5'd0;
            wreg_wb_q  <= 1'b0;
            m2reg_wb_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ans_wb_q   <= ans_wb_d;
            mdata_wb_q <= mdata_wb_d;
            rw_wb_q    <= rw_wb_d;
            wreg_wb_q  <= wreg_wb_d;
            m2reg_wb_q <= m2reg_wb_d;
            err_q      <= err_d;
        end
    end

    // Gate stall with reset so a held memory op upstream cannot freeze the pipe during reset.
    assign stall     = stall_c & reset_0;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ans_wb    = ans_wb_q;
    assign mdata_wb  = mdata_wb_q;
    assign rw_wb     = rw_wb_q;
    assign wreg_wb   = wreg_wb_q;
    assign m2reg_wb  = m2reg_wb_q;
    assign mem_err   = err_q;

endmodule
